multi_port_read_serializer: RTL
===============================

MULTI_PORT_READ_SERIALIZER -- requirements
Module: multi_port_read_serializer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, giving the word width.
REQ-002 SHALL have parameter NUM_READ_PORTS, default 2, giving the number of upstream FIFO read ports.
REQ-003 SHALL have parameter FIFO_ADDR_WIDTH, default 4, giving the upstream FIFO depth as 2^FIFO_ADDR_WIDTH.
REQ-004 SHALL have parameter BUF_DEPTH, default 4, giving local buffer entries; must be a power of 2 and >= 2*NUM_READ_PORTS.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all logic is on the rising edge.
REQ-006 SHALL have port rst_n, input, 1 bit: synchronous, active-low reset.
REQ-007 SHALL have port fifo_rd_en, output, NUM_READ_PORTS bits: per-port read requests to the upstream FIFO.
REQ-008 SHALL have port fifo_rd_data, input, NUM_READ_PORTS*DATA_WIDTH bits: port p occupies bits [p*DATA_WIDTH +: DATA_WIDTH].
REQ-009 SHALL have port fifo_rd_valid, input, NUM_READ_PORTS bits: per-port returned-word valid, one cycle after fifo_rd_en.
REQ-010 SHALL have port fifo_data_count, input, FIFO_ADDR_WIDTH+1 bits: upstream occupancy.
REQ-011 SHALL have port m_valid, output, 1 bit: output stream valid.
REQ-012 SHALL have port m_data, output, DATA_WIDTH bits: output stream data.
REQ-013 SHALL have port m_ready, input, 1 bit: output stream ready.
REQ-014 SHALL have port buf_count, output, clog2(BUF_DEPTH)+1 bits: local buffer occupancy.
REQ-015 SHALL have port overflow_err, output, 1 bit: sticky protocol error flag.

Function
REQ-016 SHALL hold a circular buffer of BUF_DEPTH words with read/write pointers carrying one extra wrap bit; pointers wrap modulo BUF_DEPTH.
REQ-017 SHALL register inflight = popcount(fifo_rd_en) every cycle, representing words due on the next cycle.
REQ-018 SHALL compute k = min(NUM_READ_PORTS, fifo_data_count, BUF_DEPTH - buf_count - inflight), saturating at 0; a same-cycle pop gives no credit.
REQ-019 SHALL drive fifo_rd_en combinationally as the low k bits set (contiguous from port 0) and all other bits 0.
REQ-020 SHALL push the words whose fifo_rd_valid bit is set, in ascending port order, into consecutive buffer slots starting at the write pointer; non-contiguous valid bits are compacted the same way.
REQ-021 SHALL present the buffer head first-word-fall-through: m_valid = (buf_count != 0); m_data = buffer[rd_ptr].
REQ-022 SHALL pop one word per cycle when m_valid && m_ready; m_data stays stable while m_valid && !m_ready.
REQ-023 SHALL update buf_count_next = buf_count + pushes - pop, with a simultaneous push and pop in the same cycle permitted.
REQ-024 SHALL, when pushes exceed BUF_DEPTH - buf_count + pop, store only the words that fit (lowest ports first), drop the rest, and set overflow_err.
REQ-025 SHALL keep overflow_err set until reset once it is set.
REQ-026 SHALL give a latency of 2 cycles from fifo_rd_en asserted to the word at m_data: 1 cycle for the upstream read and 1 cycle for the buffer write.
REQ-027 SHALL sustain 1 word/cycle on m_* when upstream has at least 1 word and m_ready stays high.

Reset
REQ-028 SHALL, while rst_n=0 at a clock edge, clear pointers, buf_count, inflight and overflow_err, and clear all buffer entries to 0.
REQ-029 SHALL force fifo_rd_en=0 while rst_n=0, regardless of fifo_data_count.
REQ-030 SHALL give reset values m_valid=0, m_data=0, buf_count=0, overflow_err=0 and fifo_rd_en=0.
REQ-031 SHALL discard fifo_rd_valid words arriving on a cycle with rst_n=0, without flagging overflow_err.
REQ-032 SHALL clear inflight when reset occurs mid-operation, so words arriving on the first cycle after deassertion are pushed normally.

Verification
REQ-033 SHALL be covered by this scenario: rst_n=0 for 2 cycles with fifo_data_count=5 -> fifo_rd_en=00, m_valid=0, m_data=0, buf_count=0, overflow_err=0.
REQ-034 SHALL be covered by this scenario: fifo_data_count=5, m_ready=1, returned words A (port 0) and B (port 1) -> cycle 0 fifo_rd_en=11; cycle 1 fifo_rd_valid=11; cycle 2 m_data=A; cycle 3 m_data=B.
REQ-035 SHALL be covered by this scenario: fifo_data_count=1 -> fifo_rd_en=01; next cycle a single push, and buf_count=1 after.
REQ-036 SHALL be covered by this scenario: m_ready=0, fifo_data_count=8 -> fifo_rd_en 11, then 11, then 00; buf_count settles at 4 and overflow_err stays 0.
REQ-037 SHALL be covered by this scenario: buffer full (4), fifo_rd_en=00, inject fifo_rd_valid=11 -> overflow_err=1 and sticky, buf_count=4, head data unchanged.
REQ-038 SHALL be covered by this scenario: reset asserted the cycle after fifo_rd_en=11 -> returned words dropped, buf_count=0 and overflow_err=0 after deassertion.

Source files
------------

// File: rtl/multi_port_read_serializer.sv
// Pulls up to NUM_READ_PORTS words per cycle from a multi-port upstream FIFO and
// serializes them through a small circular buffer onto a single valid/ready stream.
module multi_port_read_serializer #(
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned NUM_READ_PORTS  = 2,
  parameter int unsigned FIFO_ADDR_WIDTH = 4,
  parameter int unsigned BUF_DEPTH       = 4
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  output logic [NUM_READ_PORTS-1:0]              fifo_rd_en,
  input  logic [NUM_READ_PORTS*DATA_WIDTH-1:0]   fifo_rd_data,
  input  logic [NUM_READ_PORTS-1:0]              fifo_rd_valid,
  input  logic [FIFO_ADDR_WIDTH:0]               fifo_data_count,
  output logic                                   m_valid,
  output logic [DATA_WIDTH-1:0]                  m_data,
  input  logic                                   m_ready,
  output logic [$clog2(BUF_DEPTH):0]             buf_count,
  output logic                                   overflow_err
);

  localparam int unsigned PtrW  = $clog2(BUF_DEPTH);
  localparam int unsigned CntW  = PtrW + 1;
  localparam int unsigned InflW = $clog2(NUM_READ_PORTS + 1);

  logic [DATA_WIDTH-1:0] mem_q [BUF_DEPTH];
  logic [CntW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [CntW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]       count_q, count_d;
  logic [InflW-1:0]      inflight_q, inflight_d;
  logic                  overflow_q, overflow_d;

  logic                  pop;
  logic                  overflow_hit;
  logic [NUM_READ_PORTS-1:0] wr_en;
  logic [PtrW-1:0]       wr_idx [NUM_READ_PORTS];
  int                    credit_free;
  int                    credit_k;
  int                    push_free;
  int                    push_n;

  assign pop = (count_q != '0) && m_ready;

  // Read credit counts words already requested but not yet landed; a pop in
  // the same cycle is deliberately not credited.
  always_comb begin
    credit_free = int'(BUF_DEPTH) - int'(count_q) - int'(inflight_q);
    credit_k    = int'(NUM_READ_PORTS);
    if (int'(fifo_data_count) < credit_k) credit_k = int'(fifo_data_count);
    if (credit_free < credit_k) credit_k = credit_free;
    if (credit_k < 0) credit_k = 0;
    for (int p = 0; p < int'(NUM_READ_PORTS); p++) begin
      fifo_rd_en[p] = rst_n && (p < credit_k);
    end
  end

  // Compact valid words into consecutive slots; words beyond free space are dropped.
  always_comb begin
    push_free    = int'(BUF_DEPTH) - int'(count_q) + (pop ? 1 : 0);
    push_n       = 0;
    overflow_hit = 1'b0;
    for (int p = 0; p < int'(NUM_READ_PORTS); p++) begin
      wr_en[p]  = 1'b0;
      wr_idx[p] = '0;
      if (fifo_rd_valid[p]) begin
        if (push_n < push_free) begin
          wr_en[p]  = 1'b1;
          wr_idx[p] = wr_ptr_q[PtrW-1:0] + PtrW'(push_n);
          push_n    = push_n + 1;
        end else begin
          overflow_hit = 1'b1;
        end
      end
    end
  end

  always_comb begin
    wr_ptr_d   = wr_ptr_q + CntW'(push_n);
    rd_ptr_d   = rd_ptr_q + CntW'(pop);
    count_d    = count_q + CntW'(push_n) - CntW'(pop);
    inflight_d = InflW'($countones(fifo_rd_en));
    overflow_d = overflow_q | overflow_hit;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      inflight_q <= '0;
      overflow_q <= 1'b0;
      for (int i = 0; i < int'(BUF_DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      inflight_q <= inflight_d;
      overflow_q <= overflow_d;
      for (int p = 0; p < int'(NUM_READ_PORTS); p++) begin
        if (wr_en[p]) mem_q[wr_idx[p]] <= fifo_rd_data[p*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign m_valid      = (count_q != '0);
  assign m_data       = mem_q[rd_ptr_q[PtrW-1:0]];
  assign buf_count    = count_q;
  assign overflow_err = overflow_q;

endmodule
